// File: rtl/board_io_frontend.sv
// ============================================================================
// board_io_frontend : button/switch synchronise + debounce, 7-seg scan driver
// Revision 1.0
// ============================================================================
`default_nettype none

module board_io_frontend #(
  parameter int NUM_BTNS        = 2,
  parameter int NUM_SW          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_DIGITS      = 4,
  parameter int REFRESH_CYCLES  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_BTNS-1:0]     BTN_RAW,
  input  logic [NUM_SW-1:0]       SW_RAW,
  input  logic [4*NUM_DIGITS-1:0] DISP_VALUE,
  input  logic [NUM_DIGITS-1:0]   DISP_DP,
  input  logic                    DISP_LZB,
  output logic [NUM_BTNS-1:0]     BTN_LEVEL,
  output logic [NUM_BTNS-1:0]     BTN_PRESS,
  output logic [NUM_SW-1:0]       SW_SYNC,
  output logic [7:0]              CATHODES,
  output logic [NUM_DIGITS-1:0]   ANODES
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  logic [NUM_BTNS-1:0] btn_s1_q, btn_s2_q;
  logic [NUM_SW-1:0]   sw_s1_q, sw_s2_q;
  logic [NUM_BTNS-1:0] stable_q, stable_d, stable_dly_q, press_q;
  logic [DW-1:0]       db_cnt_q [NUM_BTNS];
  logic [DW-1:0]       db_cnt_d [NUM_BTNS];

  logic [RW-1:0]           rcnt_q, rcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    first_q, shadow_load;
  logic [4*NUM_DIGITS-1:0] val_sh_q, cur_val;
  logic [NUM_DIGITS-1:0]   dp_sh_q, cur_dp;
  logic                    lzb_sh_q, cur_lzb;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              cat_q, cat_d;
  logic                    nz, blank;
  logic [3:0]              cur_nib;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b1000000;  4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;  4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;  4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;  4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;  4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;  default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Counter advances only while the synchronised input disagrees with stable
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = ~stable_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      btn_s1_q     <= '0;
      btn_s2_q     <= '0;
      sw_s1_q      <= '0;
      sw_s2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt_q[i] <= '0;
    end else begin
      btn_s1_q     <= BTN_RAW;
      btn_s2_q     <= btn_s1_q;
      sw_s1_q      <= SW_RAW;
      sw_s2_q      <= sw_s1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      for (int i = 0; i < NUM_BTNS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // Scan state register; first_q forces the shadow load on the first edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rcnt_q   <= '0;
      idx_q    <= '0;
      first_q  <= 1'b1;
      val_sh_q <= '0;
      dp_sh_q  <= '0;
      lzb_sh_q <= 1'b0;
      an_q     <= '1;
      cat_q    <= 8'hFF;
    end else begin
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      an_q    <= an_d;
      cat_q   <= cat_d;
      if (shadow_load) begin
        val_sh_q <= DISP_VALUE;
        dp_sh_q  <= DISP_DP;
        lzb_sh_q <= DISP_LZB;
      end
    end
  end

  always_comb begin
    rcnt_d      = rcnt_q + 1'b1;
    idx_d       = idx_q;
    shadow_load = first_q;
    if (rcnt_q == REF_LAST) begin
      rcnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d       = '0;
        shadow_load = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // On the first edge the shadow is still empty, so use the live inputs
  always_comb begin
    cur_val = first_q ? DISP_VALUE : val_sh_q;
    cur_dp  = first_q ? DISP_DP    : dp_sh_q;
    cur_lzb = first_q ? DISP_LZB   : lzb_sh_q;
    cur_nib = cur_val[int'(idx_q)*4 +: 4];
    nz      = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx_q) && cur_val[j*4 +: 4] != 4'h0) nz = 1'b1;
    end
    blank = cur_lzb && (idx_q != '0) && !nz;
    an_d  = '1;
    cat_d = 8'hFF;
    if (!blank) begin
      an_d[idx_q] = 1'b0;
      cat_d       = {~cur_dp[idx_q], hex7(cur_nib)};
    end
  end

  assign BTN_LEVEL = stable_q;
  assign BTN_PRESS = press_q;
  assign SW_SYNC   = sw_s2_q;
  assign CATHODES  = cat_q;
  assign ANODES    = an_q;

endmodule

`default_nettype wire

// File: tb/tb_board_io_frontend.sv
// ============================================================================
// tb_board_io_frontend : directed self-checking bench for board_io_frontend
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_board_io_frontend;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  BTN_RAW = '0;
  logic [7:0]  SW_RAW = '0;
  logic [15:0] DISP_VALUE = '0;
  logic [3:0]  DISP_DP = '0;
  logic        DISP_LZB = 1'b0;
  logic [1:0]  BTN_LEVEL, BTN_PRESS;
  logic [7:0]  SW_SYNC, CATHODES;
  logic [3:0]  ANODES;

  int n_checks = 0;
  int n_errors = 0;

  board_io_frontend #(
    .NUM_BTNS(2), .NUM_SW(8), .DEBOUNCE_CYCLES(16),
    .NUM_DIGITS(4), .REFRESH_CYCLES(8)
  ) dut (
    .CLK(CLK), .RST(RST), .BTN_RAW(BTN_RAW), .SW_RAW(SW_RAW),
    .DISP_VALUE(DISP_VALUE), .DISP_DP(DISP_DP), .DISP_LZB(DISP_LZB),
    .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .SW_SYNC(SW_SYNC),
    .CATHODES(CATHODES), .ANODES(ANODES)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [7:0] exp_cat;
    int d, fr, cnt, lvl;

    // Reset state
    DISP_VALUE = 16'h1A2F;
    repeat (3) step();
    check("rst_anodes", ANODES, 4'hF);
    check("rst_cathodes", CATHODES, 8'hFF);
    check("rst_level", BTN_LEVEL, 2'b00);
    check("rst_press", BTN_PRESS, 2'b00);
    check("rst_sw", SW_SYNC, 8'h00);

    // Scan of 1A2F, no blanking
    RST = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      step();
      d = ((e - 1) / 8) % 4;
      case (d)
        0: begin exp_an = 4'b1110; exp_cat = 8'h8E; end
        1: begin exp_an = 4'b1101; exp_cat = 8'hA4; end
        2: begin exp_an = 4'b1011; exp_cat = 8'h88; end
        default: begin exp_an = 4'b0111; exp_cat = 8'hF9; end
      endcase
      check($sformatf("scan_an_e%0d", e), ANODES, exp_an);
      check($sformatf("scan_cat_e%0d", e), CATHODES, exp_cat);
    end

    // Switch synchroniser latency
    SW_RAW = 8'hA5;
    step();
    check("sw_edge1", SW_SYNC, 8'h00);
    step();
    check("sw_edge2", SW_SYNC, 8'hA5);

    // Clean press on button 0
    BTN_RAW = 2'b01;
    repeat (17) step();
    check("press_lvl_e17", BTN_LEVEL, 2'b00);
    step();
    check("press_lvl_e18", BTN_LEVEL, 2'b01);
    check("press_pulse_e18", BTN_PRESS, 2'b00);
    step();
    check("press_pulse_e19", BTN_PRESS, 2'b01);
    step();
    check("press_pulse_e20", BTN_PRESS, 2'b00);
    BTN_RAW = 2'b00;
    cnt = 0;
    repeat (30) begin
      step();
      if (BTN_PRESS[0]) cnt++;
    end
    check("release_pulses", cnt, 0);
    check("release_level", BTN_LEVEL, 2'b00);

    // Bounce on button 1: 5-cycle toggles are all rejected
    cnt = 0;
    lvl = 0;
    for (int k = 0; k < 100; k++) begin
      BTN_RAW[1] = (((k / 5) % 2) == 0);
      step();
      if (BTN_PRESS[1]) cnt++;
      if (BTN_LEVEL[1]) lvl++;
    end
    check("bounce_pulses", cnt, 0);
    check("bounce_level", lvl, 0);
    BTN_RAW[1] = 1'b1;
    repeat (17) step();
    check("bounce_lvl_e17", BTN_LEVEL[1], 1'b0);
    step();
    check("bounce_lvl_e18", BTN_LEVEL[1], 1'b1);
    step();
    check("bounce_press_e19", BTN_PRESS[1], 1'b1);
    cnt = 1;
    repeat (5) begin
      step();
      if (BTN_PRESS[1]) cnt++;
    end
    check("bounce_pulse_count", cnt, 1);

    // Asynchronous reset mid-debounce and mid-scan
    BTN_RAW = 2'b11;
    repeat (10) step();
    RST = 1'b1;
    #1;
    check("async_rst_anodes", ANODES, 4'hF);
    check("async_rst_cathodes", CATHODES, 8'hFF);
    check("async_rst_level", BTN_LEVEL, 2'b00);
    step();
    DISP_VALUE = 16'h0042;
    DISP_DP    = 4'b0001;
    DISP_LZB   = 1'b1;
    RST = 1'b0;

    // Leading-zero blanking and frame-coherent update
    for (int e = 1; e <= 48; e++) begin
      step();
      d  = ((e - 1) / 8) % 4;
      fr = (e - 1) / 32;
      exp_an = 4'hF;
      exp_cat = 8'hFF;
      if (d == 0) begin
        exp_an = 4'b1110;
        exp_cat = (fr == 0) ? 8'h24 : 8'h78;
      end else if (d == 1 && fr == 0) begin
        exp_an = 4'b1101;
        exp_cat = 8'h99;
      end
      check($sformatf("blank_an_e%0d", e), ANODES, exp_an);
      check($sformatf("blank_cat_e%0d", e), CATHODES, exp_cat);
      if (e == 17) check("rst_relock_lvl_e17", BTN_LEVEL, 2'b00);
      if (e == 18) check("rst_relock_lvl_e18", BTN_LEVEL, 2'b11);
      if (e == 10) DISP_VALUE = 16'h0007;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
